// File: rtl/timer_irq_unit_if.sv
// timer_irq_unit_if: data-memory bus plus IRQ line between CPU and interval timer
interface timer_irq_unit_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IRQ;
  modport master(output MemRd, MemWr, Addr, WriteData, input ReadData, IRQ);
  modport slave(input MemRd, MemWr, Addr, WriteData, output ReadData, IRQ);
endinterface

// File: rtl/timer_irq_unit.sv
// timer_irq_unit: memory-mapped reloading interval timer with sticky IRQ and saturating overflow count
module timer_irq_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1,
  parameter int          OVF_W     = 16
) (
  input logic             clk,
  input logic             reset,
  timer_irq_unit_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]    pre_cnt;
  logic [31:0]      th, tl;
  logic [2:0]       tcon;
  logic [OVF_W-1:0] ovf;
  logic             hit, wr, tick, ovf_evt, set_st;
  logic [1:0]       sel;
  logic [1:0]       unused_addr;
  assign unused_addr = bus.Addr[1:0];
  assign hit     = bus.Addr[31:4] == BASE_ADDR[31:4];
  assign sel     = bus.Addr[3:2];
  assign wr      = bus.MemWr & hit;
  assign tick    = tcon[0] && pre_cnt == PW'(PRESCALE - 1);
  // a TL write discards the tick, and with it any overflow it would have caused
  assign ovf_evt = tick && tl == '1 && !(wr && sel == 2'd1);
  assign set_st  = ovf_evt & tcon[1];
  assign bus.IRQ = tcon[1] & tcon[2];
  always_comb
    bus.ReadData = !(bus.MemRd && hit) ? 32'd0 :
                   sel == 2'd0 ? th :
                   sel == 2'd1 ? tl :
                   sel == 2'd2 ? {29'd0, tcon} : 32'(ovf);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre_cnt <= '0;
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      ovf     <= '0;
    end else begin
      pre_cnt <= (!tcon[0] || tick) ? '0 : pre_cnt + 1'b1;
      th      <= (wr && sel == 2'd0) ? bus.WriteData : th;
      tl      <= (wr && sel == 2'd1) ? bus.WriteData : !tick ? tl : tl == '1 ? th : tl + 32'd1;
      tcon    <= (wr && sel == 2'd2) ? {bus.WriteData[2] | set_st, bus.WriteData[1:0]}
                                     : {tcon[2] | set_st, tcon[1:0]};
      ovf     <= (wr && sel == 2'd3) ? OVF_W'(ovf_evt) : (ovf_evt && ovf != '1) ? ovf + 1'b1 : ovf;
    end
endmodule

// File: tb/tb_timer_irq_unit.sv
// tb_timer_irq_unit: directed checks of reload, prescale, sticky IRQ, overflow count and async reset
module tb_timer_irq_unit;
  localparam logic [31:0] B = 32'h4000_0000;
  logic clk = 0, reset = 1, mem_rd = 0, mem_wr = 0;
  logic [31:0] addr = 0, wdata = 0, v;
  int n_chk = 0, n_pass = 0;
  timer_irq_unit_if b1(), b4(), b2();
  assign b1.MemRd = mem_rd; assign b1.MemWr = mem_wr; assign b1.Addr = addr; assign b1.WriteData = wdata;
  assign b4.MemRd = mem_rd; assign b4.MemWr = mem_wr; assign b4.Addr = addr; assign b4.WriteData = wdata;
  assign b2.MemRd = mem_rd; assign b2.MemWr = mem_wr; assign b2.Addr = addr; assign b2.WriteData = wdata;
  timer_irq_unit #(.BASE_ADDR(B), .PRESCALE(1), .OVF_W(16)) u1(.clk(clk), .reset(reset), .bus(b1));
  timer_irq_unit #(.BASE_ADDR(B), .PRESCALE(4), .OVF_W(16)) u4(.clk(clk), .reset(reset), .bus(b4));
  timer_irq_unit #(.BASE_ADDR(B), .PRESCALE(1), .OVF_W(2))  u2(.clk(clk), .reset(reset), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_wr = 1; addr = a; wdata = d;
    @(posedge clk); #1;
    mem_wr = 0;
  endtask
  task automatic rd(input int d, input logic [31:0] a, output logic [31:0] r);
    mem_rd = 1; addr = a; #1;
    r = d == 4 ? b4.ReadData : d == 2 ? b2.ReadData : b1.ReadData;
    mem_rd = 0;
  endtask
  task automatic do_reset;
    reset = 1; step(1); reset = 0;
  endtask
  initial begin
    step(2); reset = 0;
    repeat (10) begin
      step(10);
      chk("idle_rdata", b1.ReadData, 0);
      chk("idle_irq", 32'(b1.IRQ), 0);
    end
    rd(1, B + 4, v); chk("idle_tl", v, 0);
    // reload at wrap with IRQ enabled
    do_reset;
    wr(B, 32'hFFFF_FFFC); wr(B + 4, 32'hFFFF_FFFE); wr(B + 8, 3);
    rd(1, B + 4, v); chk("t2_tl0", v, 32'hFFFF_FFFE);
    step(1);
    rd(1, B + 4, v); chk("t2_tl1", v, 32'hFFFF_FFFF);
    chk("t2_irq_pre", 32'(b1.IRQ), 0);
    step(1);
    rd(1, B + 4, v); chk("t2_reload", v, 32'hFFFF_FFFC);
    rd(1, B + 8, v); chk("t2_tcon", v, 7);
    chk("t2_irq", 32'(b1.IRQ), 1);
    wr(B + 8, 3);
    chk("t2_irq_clr", 32'(b1.IRQ), 0);
    rd(1, B + 8, v); chk("t2_tcon_clr", v, 3);
    // prescaler of 4
    do_reset;
    wr(B + 4, 0); wr(B + 8, 1);
    step(3);
    rd(4, B + 4, v); chk("t3_tl_3cyc", v, 0);
    step(1);
    rd(4, B + 4, v); chk("t3_tl_4cyc", v, 1);
    step(4);
    rd(4, B + 4, v); chk("t3_tl_8cyc", v, 2);
    wr(B + 8, 0);
    step(10);
    rd(4, B + 4, v); chk("t3_frozen", v, 2);
    wr(B + 8, 1);
    step(3);
    rd(4, B + 4, v); chk("t3_re_3cyc", v, 2);
    step(1);
    rd(4, B + 4, v); chk("t3_re_4cyc", v, 3);
    // overflow coinciding with a TCON write that clears status
    do_reset;
    wr(B, 0); wr(B + 4, 32'hFFFF_FFFD); wr(B + 8, 3);
    step(2);
    rd(1, B + 4, v); chk("t4_tl_max", v, 32'hFFFF_FFFF);
    wr(B + 8, 3);
    rd(1, B + 8, v); chk("t4_tcon_set_wins", v, 7);
    chk("t4_irq", 32'(b1.IRQ), 1);
    wr(B + 4, 32'h10);
    rd(1, B + 4, v); chk("t4_tl_write_wins", v, 32'h10);
    // overflow counting with IRQ disabled
    do_reset;
    wr(B, 32'hFFFF_FFFF); wr(B + 4, 32'hFFFF_FFFF); wr(B + 8, 1);
    step(2);
    wr(B + 8, 0);
    chk("t5_irq", 32'(b1.IRQ), 0);
    rd(1, B + 12, v); chk("t5_ovf3", v, 3);
    rd(2, B + 12, v); chk("t5_ovf3_w2", v, 3);
    rd(1, B + 8, v); chk("t5_tcon", v, 0);
    wr(B + 12, 0);
    rd(1, B + 12, v); chk("t5_ovf_clr", v, 0);
    do_reset;
    wr(B, 32'hFFFF_FFFF); wr(B + 4, 32'hFFFF_FFFF); wr(B + 8, 1);
    step(4);
    wr(B + 8, 0);
    rd(1, B + 12, v); chk("t5_ovf5", v, 5);
    rd(2, B + 12, v); chk("t5_ovf_sat", v, 3);
    wr(B + 8, 1);
    wr(B + 12, 0);
    rd(1, B + 12, v); chk("t5_clr_with_ovf", v, 1);
    // asynchronous reset mid-count, and out-of-window access
    do_reset;
    wr(B, 1234); wr(B + 4, 32'hFFFF_FFFF); wr(B + 8, 3);
    wr(B + 8, 2);
    rd(1, B + 4, v); chk("t6_tl_pre", v, 1234);
    chk("t6_irq_pre", 32'(b1.IRQ), 1);
    reset = 1; #1;
    chk("t6_irq_async", 32'(b1.IRQ), 0);
    rd(1, B + 4, v); chk("t6_tl_async", v, 0);
    reset = 0;
    step(1);
    rd(1, B + 16, v); chk("t6_oow_read", v, 0);
    wr(B + 16, 32'hFFFF_FFFF);
    rd(1, B, v); chk("t6_oow_th", v, 0);
    rd(1, B + 4, v); chk("t6_oow_tl", v, 0);
    rd(1, B + 8, v); chk("t6_oow_tcon", v, 0);
    chk("t6_oow_irq", 32'(b1.IRQ), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
